// File: rtl/radar_pkg.sv
// Shared types and default geometry for the radar sample packer and its bench.
// Default widths match the fixed 5-lane pixel bus; parametrised instances size locally.
package radar_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_LANES      = 5;
  localparam int DEF_ROWS       = 1024;
  localparam int DEF_COLS       = 1280;
  localparam int DEF_CHANNELS   = 8;
  localparam int DEF_IDX_W      = 11;
  localparam int DEF_CH_W       = 4;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] q;
    logic [DEF_DATA_WIDTH-1:0] i;
  } sample_t;

  typedef struct packed {
    sample_t [DEF_LANES-1:0] data;
    logic [DEF_IDX_W-1:0]    row;
    logic [DEF_IDX_W-1:0]    col;
    logic [DEF_CH_W-1:0]     ch;
    logic                    start;
    logic                    last;
  } pixel_beat_t;

  function automatic int lane_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/radar_scan_counter.sv
// Lane/col/row/channel scan counter chain; col-fastest, then row, then channel.
// Tag outputs describe the beat currently being filled; clear has priority over advance.
module radar_scan_counter
  import radar_pkg::*;
#(
  parameter int LANES    = DEF_LANES,
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int CH_W     = DEF_CH_W,
  parameter int LANE_W   = lane_w(LANES)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              advance,
  output logic [LANE_W-1:0] lane_cnt,
  output logic [IDX_W-1:0]  row,
  output logic [IDX_W-1:0]  col,
  output logic [CH_W-1:0]   ch,
  output logic              beat_done,
  output logic              frame_done,
  output logic              first_beat,
  output logic              last_beat
);

  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(LANES - 1);
  localparam logic [IDX_W-1:0]  COL_LAST = IDX_W'(COLS - LANES);
  localparam logic [IDX_W-1:0]  ROW_LAST = IDX_W'(ROWS - 1);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CHANNELS - 1);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [IDX_W-1:0]  row_q, row_d, col_q, col_d;
  logic [CH_W-1:0]   ch_q, ch_d;

  always_comb begin
    lane_d = lane_q;
    col_d  = col_q;
    row_d  = row_q;
    ch_d   = ch_q;
    if (clear) begin
      lane_d = '0;
      col_d  = '0;
      row_d  = '0;
      ch_d   = '0;
    end else if (advance) begin
      if (lane_q == LANE_MAX) begin
        lane_d = '0;
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            row_d = '0;
            ch_d  = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + IDX_W'(LANES);
        end
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lane_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
      ch_q   <= '0;
    end else begin
      lane_q <= lane_d;
      col_q  <= col_d;
      row_q  <= row_d;
      ch_q   <= ch_d;
    end
  end

  assign lane_cnt   = lane_q;
  assign row        = row_q;
  assign col        = col_q;
  assign ch         = ch_q;
  assign beat_done  = advance && (lane_q == LANE_MAX);
  assign first_beat = (row_q == '0) && (col_q == '0) && (ch_q == '0);
  assign last_beat  = (row_q == ROW_LAST) && (col_q == COL_LAST) && (ch_q == CH_LAST);
  assign frame_done = beat_done && last_beat;

endmodule

// File: rtl/radar_frame_packer.sv
// Packs LANES I/Q samples per output beat with row/col/channel tags and frame flags.
// Only the beat-completing sample waits for output space; output holds while !m_ready.
module radar_frame_packer
  import radar_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int CH_W       = DEF_CH_W
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          sw_clear,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [2*DATA_WIDTH-1:0]       s_data,
  input  logic                          s_last,
  input  logic                          m_ready,
  output logic                          data_vaild,
  output logic [LANES*2*DATA_WIDTH-1:0] pixel_out,
  output logic [IDX_W-1:0]              row_idx,
  output logic [IDX_W-1:0]              col_idx,
  output logic [CH_W-1:0]               channel_num,
  output logic                          data_start,
  output logic                          data_end,
  output logic                          frame_err
);

  localparam int SW = 2 * DATA_WIDTH;
  localparam int PW = LANES * SW;
  localparam int LW = lane_w(LANES);

  logic [LW-1:0]    lane_cnt;
  logic [IDX_W-1:0] cur_row, cur_col;
  logic [CH_W-1:0]  cur_ch;
  logic             beat_done, frame_done, first_beat, last_beat;
  logic             accept, early_last, cnt_clear, load;

  logic [PW-1:0]    acc_q, acc_d, pix_q, pix_d;
  logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             vld_q, vld_d, start_q, start_d, end_q, end_d, err_q, err_d;

  assign s_ready    = (lane_cnt != LW'(LANES - 1)) || !vld_q || m_ready;
  assign accept     = s_valid && s_ready;
  assign early_last = accept && s_last && !frame_done;
  assign cnt_clear  = sw_clear || early_last;
  assign load       = beat_done && !cnt_clear;

  radar_scan_counter #(
    .LANES(LANES), .ROWS(ROWS), .COLS(COLS), .CHANNELS(CHANNELS),
    .IDX_W(IDX_W), .CH_W(CH_W), .LANE_W(LW)
  ) u_scan (
    .clock(clock), .reset_n(reset_n), .clear(cnt_clear), .advance(accept),
    .lane_cnt(lane_cnt), .row(cur_row), .col(cur_col), .ch(cur_ch),
    .beat_done(beat_done), .frame_done(frame_done),
    .first_beat(first_beat), .last_beat(last_beat)
  );

  always_comb begin
    acc_d   = acc_q;
    pix_d   = pix_q;
    row_d   = row_q;
    col_d   = col_q;
    ch_d    = ch_q;
    start_d = start_q;
    end_d   = end_q;
    vld_d   = vld_q && !m_ready;
    err_d   = err_q;
    if (accept) acc_d[int'(lane_cnt)*SW +: SW] = s_data;
    // The completing sample goes straight into the output beat alongside the stored lanes.
    if (load) begin
      vld_d   = 1'b1;
      pix_d   = acc_d;
      row_d   = cur_row;
      col_d   = cur_col;
      ch_d    = cur_ch;
      start_d = first_beat;
      end_d   = last_beat;
    end
    if (cnt_clear) acc_d = '0;
    if (early_last || (frame_done && !s_last)) err_d = 1'b1;
    if (sw_clear) begin
      vld_d   = 1'b0;
      pix_d   = '0;
      row_d   = '0;
      col_d   = '0;
      ch_d    = '0;
      start_d = 1'b0;
      end_d   = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      pix_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      ch_q    <= '0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      pix_q   <= pix_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ch_q    <= ch_d;
      start_q <= start_d;
      end_q   <= end_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign data_vaild  = vld_q;
  assign pixel_out   = pix_q;
  assign row_idx     = row_q;
  assign col_idx     = col_q;
  assign channel_num = ch_q;
  assign data_start  = start_q;
  assign data_end    = end_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_radar_frame_packer.sv
// Directed bench for radar_frame_packer on a 2-lane, 4x2x2 geometry (8 beats per frame).
module tb_radar_frame_packer;

  localparam int DW = 16, LN = 2, RW = 2, CL = 4, CHN = 2, IW = 11, CW = 4;
  localparam int PW = LN * 2 * DW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          sw_clear = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
  logic [2*DW-1:0] s_data = '0;
  logic          s_ready, data_vaild, data_start, data_end, frame_err;
  logic [PW-1:0] pixel_out;
  logic [IW-1:0] row_idx, col_idx;
  logic [CW-1:0] channel_num;

  radar_frame_packer #(
    .DATA_WIDTH(DW), .LANES(LN), .ROWS(RW), .COLS(CL), .CHANNELS(CHN), .IDX_W(IW), .CH_W(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .sw_clear(sw_clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_ready(m_ready), .data_vaild(data_vaild), .pixel_out(pixel_out),
    .row_idx(row_idx), .col_idx(col_idx), .channel_num(channel_num),
    .data_start(data_start), .data_end(data_end), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [PW-1:0] pix;
    logic [IW-1:0] row, col;
    logic [CW-1:0] ch;
    logic          st, en;
  } beat_t;

  typedef struct {
    int s0; int row; int col; int ch; bit st; bit en;
  } vec_t;

  int    n_checks = 0, n_fail = 0;
  beat_t got[$];
  beat_t mb;
  vec_t  tbl[8];

  always @(negedge clock) begin
    if (reset_n && data_vaild && m_ready) begin
      mb.pix = pixel_out; mb.row = row_idx; mb.col = col_idx;
      mb.ch = channel_num; mb.st = data_start; mb.en = data_end;
      got.push_back(mb);
    end
  end

  function automatic logic [2*DW-1:0] mk(input int n);
    logic [DW-1:0] i_part;
    i_part = DW'(n);
    return {i_part ^ 16'hA500, i_part};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input int n, input bit last);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1; s_data = mk(n); s_last = last;
    for (int t = 0; t < 50; t++) begin
      @(negedge clock);
      if (s_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check($sformatf("send%0d_timeout", n), 64'd0, 64'd1);
    @(posedge clock); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic chk_beat(input int idx, input int s0, input int row, input int col,
                          input int ch, input bit st, input bit en);
    if (idx >= got.size()) begin
      check($sformatf("beat%0d_present", idx), 64'd0, 64'd1);
    end else begin
      check($sformatf("beat%0d_pix", idx), got[idx].pix, {mk(s0 + 1), mk(s0)});
      check($sformatf("beat%0d_row", idx), 64'(got[idx].row), 64'(row));
      check($sformatf("beat%0d_col", idx), 64'(got[idx].col), 64'(col));
      check($sformatf("beat%0d_ch", idx), 64'(got[idx].ch), 64'(ch));
      check($sformatf("beat%0d_start", idx), 64'(got[idx].st), 64'(st));
      check($sformatf("beat%0d_end", idx), 64'(got[idx].en), 64'(en));
    end
  endtask

  task automatic chk_frame(input string nm);
    check({nm, "_beat_count"}, 64'(got.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      chk_beat(i, tbl[i].s0, tbl[i].row, tbl[i].col, tbl[i].ch, tbl[i].st, tbl[i].en);
  endtask

  task automatic send_frame(input bit with_last);
    for (int n = 0; n < 16; n++) send(n, with_last && (n == 15));
  endtask

  initial begin
    tbl[0] = '{0,  0, 0, 0, 1'b1, 1'b0};
    tbl[1] = '{2,  0, 2, 0, 1'b0, 1'b0};
    tbl[2] = '{4,  1, 0, 0, 1'b0, 1'b0};
    tbl[3] = '{6,  1, 2, 0, 1'b0, 1'b0};
    tbl[4] = '{8,  0, 0, 1, 1'b0, 1'b0};
    tbl[5] = '{10, 0, 2, 1, 1'b0, 1'b0};
    tbl[6] = '{12, 1, 0, 1, 1'b0, 1'b0};
    tbl[7] = '{14, 1, 2, 1, 1'b0, 1'b1};

    // Reset state
    #12;
    check("rst_vld", 64'(data_vaild), 64'd0);
    check("rst_pix", pixel_out, 64'd0);
    check("rst_start", 64'(data_start), 64'd0);
    check("rst_err", 64'(frame_err), 64'd0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    check("rst_s_ready", 64'(s_ready), 64'd1);

    // Plain frame
    got.delete();
    send_frame(1'b1);
    drain();
    chk_frame("plain");
    check("plain_err", 64'(frame_err), 64'd0);

    // Output stall at beat 2
    got.delete();
    fork
      send_frame(1'b1);
      begin
        bit found;
        logic [PW-1:0] held;
        found = 1'b0;
        for (int t = 0; t < 300; t++) begin
          @(posedge clock); #1;
          if (data_vaild && got.size() == 2) begin found = 1'b1; break; end
        end
        if (!found) check("stall_trigger", 64'd0, 64'd1);
        m_ready = 1'b0;
        held = pixel_out;
        repeat (5) begin
          @(negedge clock);
          check("stall_hold_pix", pixel_out, held);
          check("stall_hold_vld", 64'(data_vaild), 64'd1);
          if (s_valid) check("stall_s_ready", 64'(s_ready), 64'(s_data[0] == 1'b0));
        end
        @(posedge clock); #1;
        m_ready = 1'b1;
      end
    join
    drain();
    chk_frame("stall");

    // Frame without s_last
    got.delete();
    for (int n = 0; n < 15; n++) send(n, 1'b0);
    check("nolast_err_before", 64'(frame_err), 64'd0);
    send(15, 1'b0);
    check("nolast_err_after", 64'(frame_err), 64'd1);
    drain();
    chk_frame("nolast");

    // Async reset mid-frame
    for (int n = 0; n < 5; n++) send(n, 1'b0);
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    check("arst_vld", 64'(data_vaild), 64'd0);
    check("arst_pix", pixel_out, 64'd0);
    check("arst_err", 64'(frame_err), 64'd0);
    check("arst_row", 64'(row_idx), 64'd0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    check("arst_s_ready", 64'(s_ready), 64'd1);
    got.delete();
    send_frame(1'b1);
    drain();
    chk_frame("after_rst");
    check("after_rst_err", 64'(frame_err), 64'd0);

    // Early s_last on sample 5
    got.delete();
    for (int n = 0; n < 5; n++) send(n, 1'b0);
    send(5, 1'b1);
    check("early_err", 64'(frame_err), 64'd1);
    check("early_no_beat", 64'(data_vaild), 64'd0);
    send(16, 1'b0);
    send(17, 1'b0);
    drain();
    check("early_beat_count", 64'(got.size()), 64'd3);
    chk_beat(0, 0, 0, 0, 0, 1'b1, 1'b0);
    chk_beat(1, 2, 0, 2, 0, 1'b0, 1'b0);
    chk_beat(2, 16, 0, 0, 0, 1'b1, 1'b0);
    send(18, 1'b1);
    check("early_err_sticky", 64'(frame_err), 64'd1);

    // sw_clear coinciding with sample 3
    got.delete();
    for (int n = 0; n < 3; n++) send(n, 1'b0);
    s_valid = 1'b1; s_data = mk(3); s_last = 1'b0; sw_clear = 1'b1;
    @(negedge clock);
    check("clr_s_ready", 64'(s_ready), 64'd1);
    @(posedge clock); #1;
    s_valid = 1'b0; sw_clear = 1'b0;
    check("clr_err", 64'(frame_err), 64'd0);
    check("clr_vld", 64'(data_vaild), 64'd0);
    send(4, 1'b0);
    send(5, 1'b0);
    drain();
    check("clr_beat_count", 64'(got.size()), 64'd2);
    chk_beat(0, 0, 0, 0, 0, 1'b1, 1'b0);
    chk_beat(1, 4, 0, 0, 0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
